// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised universal shift register. It can do a serial shift left or
//   right, a rotate, or an arithmetic shift. It can also take a parallel load.
//   It also runs a multi-position burst shift controlled by a
//   start/busy/done handshake.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   mode     00 logical, 01 rotate, 10 arithmetic, 11 hold
//   drt      direction: 1 = left (toward MSB), 0 = right
//   lft      serial input entering at q[0] on a left shift
//   rgt      serial input entering at q[WIDTH-1] on a right shift
//   en       single-step shift enable (honoured only when no burst runs)
//   load     parallel load strobe (also aborts a running burst)
//   pdata    parallel load data
//   start    burst request pulse
//   count    burst length in positions (saturates at WIDTH)
//   q        register contents
//   sout_l   q[WIDTH-1]
//   sout_r   q[0]
//   busy     burst in progress
//   done     one-cycle pulse when a burst completes
// -----------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             drt,
  input  logic             lft,
  input  logic             rgt,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CW-1:0]    rem_q,   rem_d;
  logic [1:0]       mode_q,  mode_d;
  logic             drt_q,   drt_d;
  logic [CW-1:0]    count_sat;

  // One shift step of the register for a given mode and direction.
  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       md,
    input logic             dir,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = v;
    unique case (md)
      2'b00:   r = dir ? {v[WIDTH-2:0], sl}        : {sr, v[WIDTH-1:1]};
      2'b01:   r = dir ? {v[WIDTH-2:0], v[WIDTH-1]} : {v[0], v[WIDTH-1:1]};
      2'b10:   r = dir ? {v[WIDTH-2:0], 1'b0}       : {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Bursts longer than the register are clamped. A longer burst would only
  // repeat a state that a WIDTH-long burst already reaches.
  assign count_sat = (count > CW'(WIDTH)) ? CW'(WIDTH) : count;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    drt_d   = drt_q;
    case (state_q)
      S_SHIFT: begin
        if (load) begin
          // A load abandons the burst silently. No done pulse is produced.
          data_d  = pdata;
          rem_d   = '0;
          state_d = S_IDLE;
        end else begin
          // The latched mode and direction are used here. The serial inputs
          // stay live on every cycle.
          data_d = step(data_q, mode_q, drt_q, lft, rgt);
          rem_d  = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        // IDLE and DONE behave the same. DONE exists only to drive done for
        // exactly one cycle.
        state_d = S_IDLE;
        if (load) begin
          data_d = pdata;
        end else if (start) begin
          mode_d = mode;
          drt_d  = drt;
          rem_d  = count_sat;
          state_d = (count_sat == '0) ? S_DONE : S_SHIFT;
        end else if (en) begin
          data_d = step(data_q, mode, drt, lft, rgt);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= RST_VAL;
      rem_q   <= '0;
      mode_q  <= 2'b11;
      drt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      drt_q   <= drt_d;
    end
  end

  assign q      = data_q;
  assign sout_l = data_q[WIDTH-1];
  assign sout_r = data_q[0];
  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//   Self-checking bench for univ_shift_reg with WIDTH=8. It runs directed
//   scenarios first and then randomized traffic. A cycle-level reference
//   model written with integer arithmetic checks q, busy, done and both
//   serial outputs after every edge.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

  localparam int         W   = 8;
  localparam int         CWT = $clog2(W + 1);
  localparam logic [7:0] RV  = 8'h5A;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     mode;
  logic           drt, lft, rgt, en, load, start;
  logic [7:0]     pdata;
  logic [CWT-1:0] count;
  logic [7:0]     q;
  logic           sout_l, sout_r, busy, done;

  int n_cmp = 0;
  int n_mis = 0;
  bit verbose = 1'b1;

  // Reference model state
  logic [7:0] m_q;
  logic       m_busy, m_done;
  int         m_rem;
  logic [1:0] m_mode;
  logic       m_drt;

  univ_shift_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .drt(drt), .lft(lft), .rgt(rgt),
    .en(en), .load(load), .pdata(pdata), .start(start), .count(count),
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One shift step, computed with integer arithmetic on the byte value.
  function automatic logic [7:0] ref_step(input logic [7:0] v, input logic [1:0] md,
                                          input logic dir, input logic li, input logic ri);
    int x, r;
    x = int'(v);
    case (md)
      2'd0:    r = dir ? ((x * 2) % 256 + int'(li))      : (x / 2 + int'(ri) * 128);
      2'd1:    r = dir ? ((x * 2) % 256 + x / 128)       : (x / 2 + (x % 2) * 128);
      2'd2:    r = dir ? ((x * 2) % 256)                 : (x / 2 + (x / 128) * 128);
      default: r = x;
    endcase
    return r[7:0];
  endfunction

  task automatic model_edge();
    int n;
    if (m_busy) begin
      if (load) begin
        m_q = pdata; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
      end else begin
        m_q = ref_step(m_q, m_mode, m_drt, lft, rgt);
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
      if (load) begin
        m_q = pdata;
      end else if (start) begin
        n = (int'(count) > W) ? W : int'(count);
        m_mode = mode; m_drt = drt;
        if (n == 0) m_done = 1'b1;
        else begin m_rem = n; m_busy = 1'b1; end
      end else if (en) begin
        m_q = ref_step(m_q, mode, drt, lft, rgt);
      end
    end
  endtask

  task automatic model_reset();
    m_q = RV; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
  endtask

  task automatic check_all();
    chk("q", q, m_q);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("sout_l", sout_l, m_q[7]);
    chk("sout_r", sout_r, m_q[0]);
  endtask

  // One clock: the inputs set beforehand are sampled at the edge. The model
  // is advanced and then compared, and the pulse inputs are cleared.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (verbose)
      $display("t=%0t ld=%0b st=%0b en=%0b md=%0d dr=%0b cnt=%0d -> q=%02h busy=%0b done=%0b",
               $time, load, start, en, mode, drt, count, q, busy, done);
    check_all();
    load = 1'b0; start = 1'b0; en = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; pdata = v; tick();
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b00; drt = 1'b0; lft = 1'b0; rgt = 1'b0;
    en = 1'b0; load = 1'b0; pdata = 8'h00; start = 1'b0; count = '0;
    model_reset();
    #12;
    check_all();
    chk("rst_q", q, RV);
    @(negedge clk); rst_n = 1'b1;

    // 1: load, then single-step logical shifts
    do_load(8'hA5);
    mode = 2'b00; drt = 1'b1; lft = 1'b1;
    en = 1'b1; tick();
    en = 1'b1; tick();
    chk("t1_left2", q, 8'h97);
    drt = 1'b0; rgt = 1'b0;
    en = 1'b1; tick();
    chk("t1_right1", q, 8'h4B);

    // 2: rotate-right burst of 3, then a saturating burst
    do_load(8'h81);
    mode = 2'b01; drt = 1'b0; count = CWT'(3); start = 1'b1; tick();
    mode = 2'b00; drt = 1'b1;  // live changes must not affect the burst
    for (int i = 0; i < 3; i++) begin
      chk("t2_busy", busy, 1'b1);
      tick();
    end
    chk("t2_q", q, 8'h30);
    chk("t2_done", done, 1'b1);
    tick();
    do_load(8'h81);
    mode = 2'b01; drt = 1'b0; count = CWT'(15); start = 1'b1; tick();
    for (int i = 0; i < 8; i++) tick();
    chk("t2_sat_done", done, 1'b1);
    chk("t2_sat_q", q, 8'h81);
    tick();

    // 3: arithmetic bursts
    do_load(8'h90);
    mode = 2'b10; drt = 1'b0; count = CWT'(2); start = 1'b1; tick();
    tick(); tick();
    chk("t3_asr", q, 8'hE4);
    mode = 2'b10; drt = 1'b1; count = CWT'(1); start = 1'b1; tick();
    tick();
    chk("t3_asl", q, 8'hC8);
    tick();

    // 4: load aborts a burst, start pulses ignored while busy
    do_load(8'h11);
    mode = 2'b00; drt = 1'b1; lft = 1'b0; count = CWT'(6); start = 1'b1; tick();
    start = 1'b1; count = CWT'(0); tick();
    load = 1'b1; pdata = 8'h3C; tick();
    chk("t4_q", q, 8'h3C);
    chk("t4_busy", busy, 1'b0);
    tick();
    chk("t4_nodone", done, 1'b0);

    // 5: zero-length burst and priority of load
    start = 1'b1; count = '0; tick();
    chk("t5_done", done, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_q", q, 8'h3C);
    tick();
    load = 1'b1; start = 1'b1; en = 1'b1; pdata = 8'hC3; count = CWT'(4); tick();
    chk("t5_prio_q", q, 8'hC3);
    chk("t5_prio_busy", busy, 1'b0);

    // 6: reset mid-burst between edges, then a normal burst
    mode = 2'b01; drt = 1'b1; count = CWT'(5); start = 1'b1; tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_q", q, RV);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    mode = 2'b01; drt = 1'b1; count = CWT'(2); start = 1'b1; tick();
    tick(); tick();
    chk("t6_after_q", q, 8'h69);
    chk("t6_after_done", done, 1'b1);

    // Randomized traffic
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      mode  = 2'($urandom_range(0, 3));
      drt   = 1'($urandom_range(0, 1));
      lft   = 1'($urandom_range(0, 1));
      rgt   = 1'($urandom_range(0, 1));
      en    = ($urandom_range(0, 99) < 40);
      load  = ($urandom_range(0, 99) < 5);
      start = ($urandom_range(0, 99) < 15);
      pdata = 8'($urandom());
      count = CWT'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
